// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/halt/step sequencer owning the CPU clock-enable
// Watches pc and isReset; halts on host command, breakpoint, cycle budget or program RESET.
module cpu_run_controller #(
    parameter int PC_WIDTH    = 8,
    parameter int CYCLE_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cmdValid,
    output logic                   cmdReady,
    input  logic [2:0]             cmdOp,
    input  logic [CYCLE_WIDTH-1:0] cmdArg,
    input  logic [PC_WIDTH-1:0]    pc,
    input  logic                   isReset,
    output logic                   cpuEnable,
    output logic                   running,
    output logic [1:0]             haltCause,
    output logic                   stepDone,
    output logic [CYCLE_WIDTH-1:0] cycleCount
);

    localparam logic [1:0] ST_HALTED   = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_STEPPING = 2'd2;

    localparam logic [2:0] OP_RUN         = 3'd0;
    localparam logic [2:0] OP_HALT        = 3'd1;
    localparam logic [2:0] OP_STEP        = 3'd2;
    localparam logic [2:0] OP_SET_BREAK   = 3'd3;
    localparam logic [2:0] OP_CLEAR_BREAK = 3'd4;

    localparam logic [1:0] CAUSE_HOST   = 2'd0;
    localparam logic [1:0] CAUSE_BREAK  = 2'd1;
    localparam logic [1:0] CAUSE_BUDGET = 2'd2;
    localparam logic [1:0] CAUSE_RESET  = 2'd3;

    localparam logic [CYCLE_WIDTH-1:0] CYC_ONE = 1;

    logic [1:0]             state;
    logic                   breakEnable;
    logic [PC_WIDTH-1:0]    breakAddr;
    logic [CYCLE_WIDTH-1:0] budget;
    logic                   skipBreak;
    logic                   bpHit;
    logic                   accept;

    assign cmdReady = (state != ST_STEPPING);
    assign accept   = cmdValid && cmdReady;
    assign running  = (state == ST_RUNNING);

    always_comb begin
        bpHit = breakEnable && (pc == breakAddr) && !skipBreak;
        case (state)
            ST_RUNNING:  cpuEnable = !bpHit;
            ST_STEPPING: cpuEnable = 1'b1;
            default:     cpuEnable = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_HALTED;
            haltCause   <= CAUSE_HOST;
            stepDone    <= 1'b0;
            cycleCount  <= '0;
            breakEnable <= 1'b0;
            breakAddr   <= '0;
            budget      <= '0;
            skipBreak   <= 1'b0;
        end else begin
            stepDone <= (state == ST_STEPPING);
            if (cpuEnable && (cycleCount != '1))
                cycleCount <= cycleCount + CYC_ONE;

            // accept is never true in STEPPING, so breakpoint edits only land in HALTED/RUNNING
            if (accept && (cmdOp == OP_SET_BREAK)) begin
                breakAddr   <= cmdArg[PC_WIDTH-1:0];
                breakEnable <= 1'b1;
            end
            if (accept && (cmdOp == OP_CLEAR_BREAK))
                breakEnable <= 1'b0;

            case (state)
                ST_HALTED: begin
                    if (accept && (cmdOp == OP_RUN)) begin
                        state     <= ST_RUNNING;
                        budget    <= cmdArg;
                        skipBreak <= 1'b1;
                    end else if (accept && (cmdOp == OP_STEP)) begin
                        state <= ST_STEPPING;
                    end
                end
                ST_RUNNING: begin
                    if (cpuEnable)
                        skipBreak <= 1'b0;
                    if (accept && (cmdOp == OP_RUN))
                        budget <= cmdArg;
                    else if (cpuEnable && (budget != '0))
                        budget <= budget - CYC_ONE;

                    if (accept && (cmdOp == OP_HALT)) begin
                        state     <= ST_HALTED;
                        haltCause <= CAUSE_HOST;
                    end else if (cpuEnable && isReset) begin
                        state     <= ST_HALTED;
                        haltCause <= CAUSE_RESET;
                    end else if (cpuEnable && (budget == CYC_ONE)) begin
                        state     <= ST_HALTED;
                        haltCause <= CAUSE_BUDGET;
                    end else if (bpHit) begin
                        state     <= ST_HALTED;
                        haltCause <= CAUSE_BREAK;
                    end
                end
                ST_STEPPING: begin
                    state     <= ST_HALTED;
                    haltCause <= isReset ? CAUSE_RESET : CAUSE_HOST;
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed plus random bench for cpu_run_controller
// A behavioural model tracks run state, budget and counters and is compared every cycle.
module tb_cpu_run_controller;

    localparam int PW   = 8;
    localparam int CW   = 10;
    localparam int CMAX = (1 << CW) - 1;

    localparam int MS_HALT = 0;
    localparam int MS_RUN  = 1;
    localparam int MS_STEP = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmdValid;
    logic          cmdReady;
    logic [2:0]    cmdOp;
    logic [CW-1:0] cmdArg;
    logic [PW-1:0] pc;
    logic          isReset;
    logic          cpuEnable;
    logic          running;
    logic [1:0]    haltCause;
    logic          stepDone;
    logic [CW-1:0] cycleCount;

    cpu_run_controller #(.PC_WIDTH(PW), .CYCLE_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdReady(cmdReady),
        .cmdOp(cmdOp), .cmdArg(cmdArg), .pc(pc), .isReset(isReset),
        .cpuEnable(cpuEnable), .running(running), .haltCause(haltCause),
        .stepDone(stepDone), .cycleCount(cycleCount)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    int m_state, m_cause, m_count, m_budget, m_ba;
    bit m_be, m_skip, m_stepdone;
    bit last_en;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = MS_HALT; m_cause = 0; m_count = 0; m_budget = 0;
        m_ba = 0; m_be = 0; m_skip = 0; m_stepdone = 0;
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model.
    task automatic cyc(input bit rst, input bit v, input int op, input int arg,
                       input int p, input bit isr);
        bit exp_ready, bp, exp_en, acc;
        int reason;
        reset = rst; cmdValid = v; cmdOp = op[2:0]; cmdArg = arg[CW-1:0];
        pc = p[PW-1:0]; isReset = isr;
        @(negedge clock);
        exp_ready = (m_state != MS_STEP);
        bp        = m_be && ((p % 256) == m_ba) && !m_skip;
        exp_en    = (m_state == MS_RUN && !bp) || (m_state == MS_STEP);
        chk("cmdReady", cmdReady, exp_ready);
        chk("cpuEnable", cpuEnable, exp_en);
        chk("running", running, m_state == MS_RUN);
        chk("haltCause", haltCause, m_cause);
        chk("stepDone", stepDone, m_stepdone);
        chk("cycleCount", cycleCount, m_count);
        last_en = exp_en;
        if (rst) begin
            model_reset();
        end else begin
            acc = v && exp_ready;
            if (exp_en && m_count < CMAX) m_count++;
            m_stepdone = (m_state == MS_STEP);
            if (acc && op == 3) begin m_be = 1; m_ba = arg % 256; end
            if (acc && op == 4) m_be = 0;
            if (m_state == MS_STEP) begin
                m_state = MS_HALT;
                m_cause = isr ? 3 : 0;
            end else if (m_state == MS_HALT) begin
                if (acc && op == 0) begin m_state = MS_RUN; m_budget = arg; m_skip = 1; end
                else if (acc && op == 2) m_state = MS_STEP;
            end else begin
                reason = -1;
                if (acc && op == 1)                 reason = 0;
                else if (exp_en && isr)             reason = 3;
                else if (exp_en && m_budget == 1)   reason = 2;
                else if (bp)                        reason = 1;
                if (exp_en) m_skip = 0;
                if (acc && op == 0)                 m_budget = arg;
                else if (exp_en && m_budget != 0)   m_budget--;
                if (reason >= 0) begin m_state = MS_HALT; m_cause = reason; end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int p);
        cyc(0, 0, 0, 0, p, 0);
    endtask

    task automatic cmd(input int op, input int arg, input int p);
        cyc(0, 1, op, arg, p, 0);
    endtask

    int pc_sim;
    int rop;

    initial begin
        reset = 1; cmdValid = 0; cmdOp = 0; cmdArg = 0; pc = 0; isReset = 0;
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        chk("rst_count", cycleCount, 0);
        chk("rst_cause", haltCause, 0);
        chk("rst_running", running, 0);
        chk("rst_ready", cmdReady, 1);

        // free run, pc 0..5
        cmd(0, 0, 0);
        for (int i = 0; i < 6; i++) idle(i);
        chk("run6_count", cycleCount, 6);
        chk("run6_running", running, 1);
        cmd(1, 0, 6);
        chk("host_halt_cause", haltCause, 0);
        chk("host_halt_count", cycleCount, 7);

        // breakpoint at 3, then resume past it
        cyc(1, 0, 0, 0, 0, 0);
        cmd(3, 3, 0);
        cmd(0, 0, 0);
        for (int i = 0; i < 4; i++) idle(i);
        chk("bp_running", running, 0);
        chk("bp_cause", haltCause, 1);
        chk("bp_count", cycleCount, 3);
        cmd(0, 0, 3);
        idle(3);
        chk("bp_skip_count", cycleCount, 4);
        idle(4);
        cmd(1, 0, 5);

        // cycle budget of 4
        cyc(1, 0, 0, 0, 0, 0);
        cmd(0, 4, 0);
        for (int i = 0; i < 6; i++) idle(i);
        chk("budget_cause", haltCause, 2);
        chk("budget_count", cycleCount, 4);

        // program RESET on the third enabled cycle
        cyc(1, 0, 0, 0, 0, 0);
        cmd(0, 0, 0);
        idle(0); idle(1);
        cyc(0, 0, 0, 0, 2, 1);
        chk("preset_cause", haltCause, 3);
        chk("preset_running", running, 0);
        chk("preset_count", cycleCount, 3);

        // single step and back-to-back step
        cyc(1, 0, 0, 0, 0, 0);
        cmd(2, 0, 0);
        chk("step_ready", cmdReady, 0);
        chk("step_enable", cpuEnable, 1);
        cmd(2, 0, 0);
        chk("step_done", stepDone, 1);
        chk("step_ready_back", cmdReady, 1);
        chk("step_count", cycleCount, 1);
        cmd(2, 0, 1);
        idle(2);
        chk("step2_count", cycleCount, 2);
        cmd(2, 0, 2);
        cyc(0, 0, 0, 0, 2, 1);
        chk("step_reset_cause", haltCause, 3);

        // HALT and isReset together, then reset mid-run
        cyc(1, 0, 0, 0, 0, 0);
        cmd(0, 0, 0);
        idle(0);
        cyc(0, 1, 1, 0, 1, 1);
        chk("halt_prio_cause", haltCause, 0);
        cmd(0, 0, 2);
        idle(2); idle(3);
        cyc(1, 0, 0, 0, 4, 0);
        chk("midrst_running", running, 0);
        chk("midrst_count", cycleCount, 0);
        chk("midrst_enable", cpuEnable, 0);

        // counter saturation
        cmd(0, 0, 0);
        for (int i = 0; i < CMAX + 8; i++) idle(i % 256);
        chk("sat_count", cycleCount, CMAX);
        cyc(1, 0, 0, 0, 0, 0);

        // random traffic with a pc that advances on enabled cycles
        pc_sim = 0;
        for (int n = 0; n < 4000; n++) begin
            rop = $urandom_range(0, 7);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) == 0, rop,
                (rop == 3) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 6)),
                pc_sim, $urandom_range(0, 24) == 0);
            if (last_en)
                pc_sim = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                                     : (pc_sim + 1) % 16;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Execution sequencer for the accumulator CPU.
- Owns the CPU clock-enable and decides when the core advances.
- Supports host commands run / halt / single-step, one PC breakpoint, an optional cycle budget, and auto-halt when the program executes RESET.
- Sits between the host/debug command port and the CPU; watches the CPU's pc and isReset outputs.

Parameters:
- PC_WIDTH, 8, width of the CPU program counter.
- CYCLE_WIDTH, 16, width of the cycle budget, the cycle counter and cmdArg. Must be >= PC_WIDTH.

Ports:
- clock  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- cmdValid  input  1  host command valid.
- cmdReady  output  1  controller can accept a command.
- cmdOp  input  3  0=RUN, 1=HALT, 2=STEP, 3=SET_BREAK, 4=CLEAR_BREAK, 5-7 reserved.
- cmdArg  input  CYCLE_WIDTH  RUN: cycle budget (0 = unlimited). SET_BREAK: breakpoint address in [PC_WIDTH-1:0].
- pc  input  PC_WIDTH  current CPU program counter.
- isReset  input  1  CPU is executing the RESET opcode this cycle.
- cpuEnable  output  1  CPU advances (pc/accumulator/register update) on this posedge.
- running  output  1  state is RUNNING.
- haltCause  output  2  0=HOST, 1=BREAKPOINT, 2=BUDGET, 3=PROGRAM_RESET.
- stepDone  output  1  one-cycle pulse, the cycle after a step executes.
- cycleCount  output  CYCLE_WIDTH  total enabled cycles since reset, saturating.

Behaviour:
- Reset values:
  - state=HALTED, cpuEnable=0, running=0, haltCause=HOST, stepDone=0, cycleCount=0.
  - breakEnable=0, breakAddr=0, budget=0, skipBreak=0.
  - Reset mid-run wins over everything in that cycle.
- Command handshake:
  - cmdReady = (state != STEPPING).
  - A command is accepted on a posedge with cmdValid && cmdReady; its effect is visible from the next cycle.
  - Reserved ops are accepted with no effect.
- States: HALTED, RUNNING, STEPPING. All registered; cpuEnable is combinational from state, pc and registered flags.
- bpHit = breakEnable && (pc == breakAddr) && !skipBreak.
- cpuEnable:
  - RUNNING: 1 when !bpHit.
  - STEPPING: 1 (breakpoint ignored).
  - HALTED: 0.
- HALTED:
  - RUN: go to RUNNING; budget <= cmdArg; skipBreak <= 1 (resume from a breakpoint without re-triggering).
  - STEP: go to STEPPING.
  - HALT: no effect, haltCause unchanged.
- RUNNING transitions, evaluated at posedge, highest priority first:
  1. Accepted HALT: to HALTED, cause HOST. The current cycle still executes if cpuEnable=1.
  2. cpuEnable && isReset: to HALTED, cause PROGRAM_RESET. The RESET instruction does execute.
  3. cpuEnable && budget==1: to HALTED, cause BUDGET.
  4. bpHit: to HALTED, cause BREAKPOINT; CPU not enabled this cycle.
  5. Accepted RUN while RUNNING: reload budget from cmdArg, stay RUNNING.
- Budget:
  - Decrements on each enabled cycle when non-zero.
  - 0 means unlimited and is never decremented.
- skipBreak: cleared after the first enabled cycle in RUNNING.
- STEPPING:
  - Lasts exactly one cycle with cpuEnable=1, then HALTED, cause HOST.
  - stepDone=1 in the following cycle only.
  - If isReset was high during the step, cause is PROGRAM_RESET instead.
- SET_BREAK / CLEAR_BREAK:
  - Accepted in HALTED or RUNNING; do not change state.
  - SET_BREAK: breakAddr <= cmdArg[PC_WIDTH-1:0], breakEnable <= 1.
  - CLEAR_BREAK: breakEnable <= 0.
  - A new breakpoint applies from the next cycle.
- cycleCount: +1 per cycle with cpuEnable=1; saturates at all-ones.
- Stable pc while halted: the CPU holds pc; the controller never writes pc.

Test Plan:
- Reset, then RUN arg=0, pc sweeping 0..5 → cpuEnable=1 from the cycle after accept; running=1; cycleCount=6 after 6 cycles.
- SET_BREAK arg=3, then RUN arg=0 → cpuEnable=0 in the cycle pc=3; HALTED with haltCause=1. A second RUN executes pc=3 (skipBreak), cycleCount +1.
- RUN arg=4 with no breakpoint → exactly 4 enabled cycles, then HALTED, haltCause=2, cycleCount=4.
- RUN arg=0, drive isReset=1 on the 3rd enabled cycle → that cycle enabled; then HALTED, haltCause=3, running=0.
- From HALTED, STEP → cmdReady=0 and cpuEnable=1 for one cycle; stepDone=1 the next cycle; cycleCount +1; back-to-back STEP accepted only once cmdReady=1.
- While RUNNING, assert HALT and isReset in the same cycle → haltCause=0 (HOST priority). Reset during RUNNING → all outputs return to reset values next cycle.
